// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and helpers for the HI/LO multiply unit
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_BUSY  = 2'b10
    } state_e;

    localparam int MUL_CYCLES = 32;

    // Turns the signed high word into the unsigned one; the low word is identical for both.
    function automatic logic [31:0] unsigned_hi(input logic [31:0] hi_s, input logic [31:0] a,
                                                input logic [31:0] b);
        return hi_s + (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
    endfunction

endpackage

// File: rtl/mult_ctrl_mul.sv
// mult_ctrl_mul: iterative 32x32 signed shift-add multiplier, one bit per cycle, no reset
module mult_ctrl_mul
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        start,
    input  logic [31:0] multiplier,
    input  logic [31:0] multiplicand,
    output logic        ready,
    output logic [63:0] product
);

    logic [32:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] mcand;
    logic [5:0]  cnt;
    logic [32:0] addend;
    logic [32:0] sum;

    assign ready   = (cnt == 6'd0);
    assign product = {acc_hi[31:0], acc_lo};

    // The multiplier's sign bit carries negative weight, so the last step subtracts.
    always_comb begin
        addend = acc_lo[0] ? (cnt == 6'd1 ? -{mcand[31], mcand} : {mcand[31], mcand}) : 33'd0;
        sum    = acc_hi + addend;
    end

    // Load on start while idle, then add-and-shift right once per cycle.
    always_ff @(posedge clk) begin
        if (start && ready) begin
            acc_hi <= 33'd0;
            acc_lo <= multiplier;
            mcand  <= multiplicand;
            cnt    <= 6'(MUL_CYCLES);
        end else if (!ready) begin
            {acc_hi, acc_lo} <= {sum[32], sum, acc_lo[31:1]};
            cnt              <= cnt - 6'd1;
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: HI/LO unit control -- MULT/MULTU sequencing, MTHI/MTLO writes and MFHI/MFLO reads
module mult_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy
);

    state_e      state, state_nx;
    logic [31:0] hi, lo, a, b;
    logic        uns;
    logic        is_mul;
    logic        mul_start, mul_ready;
    logic [63:0] mul_prod;

    assign is_mul  = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign busy    = (state != ST_IDLE);
    assign stall   = busy && (op_valid || mf_req);
    assign mf_data = mf_sel ? hi : lo;

    mult_ctrl_mul u_mul (
        .clk          (clk),
        .start        (mul_start),
        .multiplier   (a),
        .multiplicand (b),
        .ready        (mul_ready),
        .product      (mul_prod)
    );

    // Next state: START waits for the multiplier to be free, BUSY waits for its result.
    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        case (state)
            ST_IDLE:  state_nx = (op_valid && is_mul) ? ST_START : ST_IDLE;
            ST_START: begin
                mul_start = 1'b1;
                state_nx  = mul_ready ? ST_BUSY : ST_START;
            end
            ST_BUSY:  state_nx = mul_ready ? ST_IDLE : ST_BUSY;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State, operand latches and HI/LO; ops are only taken in IDLE, results only leave BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
            a     <= 32'd0;
            b     <= 32'd0;
            uns   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && op_valid) begin
                if (op_code == OP_MTHI) hi <= rs_val;
                if (op_code == OP_MTLO) lo <= rs_val;
                if (is_mul) begin
                    a   <= rs_val;
                    b   <= rt_val;
                    uns <= (op_code == OP_MULTU);
                end
            end
            if (state == ST_BUSY && mul_ready) begin
                hi <= uns ? unsigned_hi(mul_prod[63:32], a, b) : mul_prod[63:32];
                lo <= mul_prod[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: randomized and directed checks of mult_ctrl against an arithmetic HI/LO model
module tb_mult_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mult_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mf_req   (mf_req),
        .mf_sel   (mf_sel),
        .mf_data  (mf_data),
        .stall    (stall),
        .busy     (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic uns, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return uns ? ({32'd0, x} * {32'd0, y}) : 64'(sx * sy);
    endfunction

    task automatic mult_run(input logic [1:0] code, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        op_valid = 1'b1; op_code = code; rs_val = x; rt_val = y; mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        vectors++;
        if (mf_data !== old_hi) begin errors++; $display("FAIL %s same-cycle read: got %h exp %h", name, mf_data, old_hi); end
        tick;
        op_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            mf_sel = n[0];
            #1;
            vectors++;
            if (stall !== 1'b1 || mf_data !== (n[0] ? old_hi : old_lo)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: stall=%b data=%h exp stall=1 data=%h", name, n, stall, mf_data, n[0] ? old_hi : old_lo);
            end
            tick;
            n++;
        end
        mf_req = 1'b0;
        vectors++;
        if (n !== 34) begin errors++; $display("FAIL %s latency: got %0d exp 34", name, n); end
        m_hi = exp_hi;
        m_lo = exp_lo;
        mf_sel = 1'b1; #1;
        vectors++;
        if (mf_data !== m_hi) begin errors++; $display("FAIL %s HI: got %h exp %h", name, mf_data, m_hi); end
        mf_sel = 1'b0; #1;
        vectors++;
        if (mf_data !== m_lo) begin errors++; $display("FAIL %s LO: got %h exp %h", name, mf_data, m_lo); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'hDEAD_BEEF; mf_req = 1'b1;
        tick;
        tick;
        op_valid = 1'b0; mf_req = 1'b0;
        tick;
        rst_n = 1'b1;
        mf_req = 1'b1; mf_sel = 1'b1; #1;
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b exp 0", busy); end
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b exp 0", stall); end
        vectors++;
        if (mf_data !== 32'd0) begin errors++; $display("FAIL reset HI: got %h exp 0", mf_data); end
        mf_sel = 1'b0; #1;
        vectors++;
        if (mf_data !== 32'd0) begin errors++; $display("FAIL reset LO: got %h exp 0", mf_data); end
        mf_req = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_directed;
        mult_run(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
        mult_run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        mult_run(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1xm1");
        mult_run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
    endtask

    task automatic test_mt_read;
        op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'h1234_5678; mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        vectors++;
        if (mf_data !== m_hi) begin errors++; $display("FAIL mthi no-bypass: got %h exp %h", mf_data, m_hi); end
        tick;
        op_code = OP_MTLO; rs_val = 32'hCAFE_F00D; mf_sel = 1'b1; #1;
        m_hi = 32'h1234_5678;
        vectors++;
        if (mf_data !== m_hi) begin errors++; $display("FAIL mthi after edge: got %h exp %h", mf_data, m_hi); end
        mf_sel = 1'b0; #1;
        vectors++;
        if (mf_data !== m_lo) begin errors++; $display("FAIL mtlo no-bypass: got %h exp %h", mf_data, m_lo); end
        tick;
        op_valid = 1'b0; #1;
        m_lo = 32'hCAFE_F00D;
        vectors++;
        if (mf_data !== m_lo) begin errors++; $display("FAIL mtlo after edge: got %h exp %h", mf_data, m_lo); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mt busy: got %b exp 0", busy); end
        mf_req = 1'b0;
    endtask

    task automatic test_stall_read;
        int n;
        logic [63:0] p;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        p = ref_prod(1'b0, x, y);
        op_valid = 1'b1; op_code = OP_MULT; rs_val = x; rt_val = y;
        tick;
        op_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        mf_req = 1'b1; mf_sel = 1'b1;
        n = 0;
        #1;
        while (busy === 1'b1 && n < 200) begin
            vectors++;
            if (stall !== 1'b1) begin errors++; $display("FAIL mf stall at E%0d: got %b exp 1", n + 5, stall); end
            tick;
            n++;
        end
        vectors++;
        if (n !== 29) begin errors++; $display("FAIL mf stall length: got %0d exp 29", n); end
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mf stall release: got %b exp 0", stall); end
        m_hi = p[63:32];
        m_lo = p[31:0];
        vectors++;
        if (mf_data !== m_hi) begin errors++; $display("FAIL mf new HI: got %h exp %h", mf_data, m_hi); end
        mf_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [63:0] p;
        logic [31:0] x, y, v;
        x = $urandom; y = $urandom; v = $urandom;
        p = ref_prod(1'b1, x, y);
        op_valid = 1'b1; op_code = OP_MULTU; rs_val = x; rt_val = y;
        tick;
        op_code = OP_MTHI; rs_val = v; mf_sel = 1'b1;
        n = 0;
        #1;
        while (busy === 1'b1 && n < 200) begin
            vectors++;
            if (stall !== 1'b1 || mf_data !== m_hi) begin
                errors++;
                $display("FAIL b2b held op cycle %0d: stall=%b data=%h exp stall=1 data=%h", n, stall, mf_data, m_hi);
            end
            tick;
            n++;
        end
        vectors++;
        if (n !== 34) begin errors++; $display("FAIL b2b latency: got %0d exp 34", n); end
        vectors++;
        if (mf_data !== p[63:32]) begin errors++; $display("FAIL b2b product HI: got %h exp %h", mf_data, p[63:32]); end
        tick;
        op_valid = 1'b0; #1;
        m_hi = v;
        m_lo = p[31:0];
        vectors++;
        if (mf_data !== m_hi) begin errors++; $display("FAIL b2b MTHI after idle: got %h exp %h", mf_data, m_hi); end
        mf_sel = 1'b0; #1;
        vectors++;
        if (mf_data !== m_lo) begin errors++; $display("FAIL b2b LO: got %h exp %h", mf_data, m_lo); end
    endtask

    task automatic test_reset_mid;
        int n;
        op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'h0001_2345; rt_val = 32'h0006_789A;
        tick;
        op_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        mf_req = 1'b1; mf_sel = 1'b1; #1;
        vectors++;
        if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midreset busy/stall: got %b/%b exp 0/0", busy, stall); end
        vectors++;
        if (mf_data !== 32'd0) begin errors++; $display("FAIL midreset HI: got %h exp 0", mf_data); end
        mf_req = 1'b0;
        op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'd2; rt_val = 32'd3;
        tick;
        op_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            mf_sel = n[0]; #1;
            vectors++;
            if (mf_data !== 32'd0) begin errors++; $display("FAIL midreset stale write cycle %0d: got %h exp 0", n, mf_data); end
            tick;
            n++;
        end
        vectors++;
        if (n !== 56) begin errors++; $display("FAIL midreset wait: got %0d exp 56", n); end
        m_lo = 32'd6;
        mf_sel = 1'b1; #1;
        vectors++;
        if (mf_data !== m_hi) begin errors++; $display("FAIL midreset HI: got %h exp %h", mf_data, m_hi); end
        mf_sel = 1'b0; #1;
        vectors++;
        if (mf_data !== m_lo) begin errors++; $display("FAIL midreset LO: got %h exp %h", mf_data, m_lo); end
    endtask

    task automatic test_random;
        logic [1:0]  code;
        logic [31:0] x, y;
        logic [63:0] p;
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h7FFF_FFFF;
        for (int k = 0; k < 24; k++) begin
            code = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if (code == OP_MULT || code == OP_MULTU) begin
                p = ref_prod(code == OP_MULTU, x, y);
                mult_run(code, x, y, p[63:32], p[31:0], "random_mul");
            end else begin
                op_valid = 1'b1; op_code = code; rs_val = x; mf_req = 1'b1; mf_sel = code == OP_MTHI;
                #1;
                vectors++;
                if (mf_data !== (mf_sel ? m_hi : m_lo)) begin errors++; $display("FAIL random mt pre: got %h exp %h", mf_data, mf_sel ? m_hi : m_lo); end
                tick;
                op_valid = 1'b0; mf_req = 1'b0;
                if (code == OP_MTHI) m_hi = x; else m_lo = x;
                #1;
                vectors++;
                if (mf_data !== x) begin errors++; $display("FAIL random mt post: got %h exp %h", mf_data, x); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_directed;
        test_mt_read;
        test_stall_read;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port SHALL be clk and the reset port rst_n.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1: synchronous active-low reset.
REQ-004 Port op_valid, input, 1: HI/LO-unit instruction presented this cycle.
REQ-005 Port op_code, input, 2: 00 MULT, 01 MULTU, 10 MTHI, 11 MTLO.
REQ-006 Port rs_val, input, 32: operand A (MULT/MULTU) or write data (MTHI/MTLO).
REQ-007 Port rt_val, input, 32: operand B (MULT/MULTU).
REQ-008 Port mf_req, input, 1: MFHI/MFLO read request.
REQ-009 Port mf_sel, input, 1: 0 selects LO, 1 selects HI.
REQ-010 Port mf_data, output, 32: selected HI/LO register value, combinational from registers.
REQ-011 Port stall, output, 1: pipeline must hold its current op/mf request.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 States SHALL be IDLE, START and BUSY; busy = (state != IDLE).
REQ-014 Stall SHALL be combinational: busy && (op_valid || mf_req); the requester holds op_valid, op_code, operands, mf_req and mf_sel stable while stall = 1.
REQ-015 In IDLE, op_valid with MTHI or MTLO SHALL write rs_val to HI or LO at that edge; the state stays IDLE.
REQ-016 In IDLE, op_valid with MULT or MULTU SHALL latch rs_val, rt_val and the signed/unsigned flag, and move to START.
REQ-017 START SHALL drive the multiplier start input high; when the multiplier ready is 1 at the edge, the state moves to BUSY, otherwise it stays in START.
REQ-018 BUSY SHALL wait for the multiplier ready; at the first edge with ready = 1, it writes product[63:32] to HI and product[31:0] to LO, with the unsigned correction applied, and returns to IDLE.
REQ-019 Latency SHALL be as follows, with no multiplier backlog: accept at edge E0, multiplier load at E1, HI/LO written at E34; busy is low from E34.
REQ-020 The multiplier computes a signed product; for MULTU, the written HI SHALL be HI_s + (A[31] ? B : 0) + (B[31] ? A : 0) mod 2^32, and LO SHALL be unchanged.
REQ-021 Arithmetic SHALL use 32-bit wrap-around with no overflow flag; the operand 0x80000000 SHALL be handled as the multiplier produces it, without special-casing.
REQ-022 mf_data SHALL never bypass: a same-cycle MTHI/MTLO or product write becomes visible only after the edge.
REQ-023 If op_valid and mf_req occur in the same IDLE cycle, the read SHALL return the pre-edge value and the op SHALL be accepted.
REQ-024 An op_valid with an op_code arriving in START or BUSY SHALL NOT be accepted until the cycle after the return to IDLE.

Reset
REQ-025 While rst_n = 0 at an edge, the state SHALL become IDLE, HI and LO 0, and latched operands 0; stall and busy read 0 in the following cycle.
REQ-026 The multiplier has no reset; after a reset taken mid-multiply, the next MULT/MULTU SHALL wait in START until the multiplier ready is 1, and the stale product SHALL never be written.
REQ-027 Reset SHALL take priority over every simultaneous op or read.

Structure
REQ-028 Package mdu_pkg SHALL hold the op_code encodings, the state encoding and the constant MUL_CYCLES = 32.
REQ-029 A single sub-module instance named u_mul of the existing iterative signed multiplier SHALL be used, with clk, start, multiplier = A, multiplicand = B, ready and product.
REQ-030 The correction adder and HI/LO registers SHALL reside in mult_ctrl.

Verification
REQ-031 MULT rs = 0xFFFFFFFD, rt = 7 -> at E34, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy high for E0..E33.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; MULT with the same operands -> HI = 0, LO = 1.
REQ-033 MULT 0x80000000 x 0x80000000 -> HI = 0x40000000, LO = 0.
REQ-034 mf_req = 1, mf_sel = 1 held from E5 during a multiply -> stall = 1 until E34, then mf_data = new HI with stall = 0.
REQ-035 Reset at E10 of a multiply, then immediate MULT 2 x 3 -> held in START until the stale run ends; HI = 0, LO = 6; no stale value written.
REQ-036 MTHI 0x12345678 with mf_req HI in the same cycle -> mf_data = old HI that cycle, 0x12345678 the next cycle.
